// File: rtl/axis_ctr_pkg.sv
// Shared definitions for the AXI-Stream counter link (transmitter and receiver).
// Holds the checker state encoding and the stall-LFSR constants so both ends of
// the link can build matching stall generators.
package axis_ctr_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ctr_state_e;

    localparam int unsigned      LFSR_W            = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/axis_ctr_rx_if.sv
// AXI-Stream handshake bundle for the counter link.
// master: transmitter side (drives tvalid/tdata, sees tready)
// slave : receiver side (sees tvalid/tdata, drives tready)
interface axis_ctr_rx_if #(
    parameter int unsigned DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_lfsr16.sv
// 16-bit Galois LFSR used as a pseudo-random stall source.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset (state <- SEED)
//   en            advance one step this cycle
//   state         current LFSR value (registered)
//   state_next_c  value the LFSR steps to next (combinational)
module axis_lfsr16
    import axis_ctr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next_c
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Step value is exposed even when not enabled so callers can look ahead.
    always_comb begin
        state_next_c = lfsr_step(lfsr_q);
        lfsr_d       = lfsr_q;
        if (en) begin
            lfsr_d = state_next_c;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/axis_ctr_rx.sv
// Counter-stream receiver: checks that accepted beats count up from 0 by 1
// (mod 2^N), resyncs on mismatch, and keeps transfer/error statistics.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   s_axis         AXI-Stream slave (tvalid/tdata in, registered tready out)
//   rx_count       accepted transfers, wraps at 2^32
//   err_count      mismatched transfers, saturating
//   err_sticky     set on first mismatch, cleared by reset only
//   last_bad_data  tdata of most recent mismatched beat
//   last_expected  expected value at most recent mismatch
//   halted         high while the checker is halted
module axis_ctr_rx
    import axis_ctr_pkg::*;
#(
    parameter int unsigned       byte_width    = 4,
    parameter bit                STALL_MODE    = 1'b0,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_DEFAULT_SEED,
    parameter bit                HALT_ON_ERROR = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetn,
    axis_ctr_rx_if.slave            s_axis,
    output logic [31:0]             rx_count,
    output logic [15:0]             err_count,
    output logic                    err_sticky,
    output logic [8*byte_width-1:0] last_bad_data,
    output logic [8*byte_width-1:0] last_expected,
    output logic                    halted
);

    localparam int unsigned N = 8 * byte_width;

    ctr_state_e state_q, state_d;

    logic [N-1:0] expected_q, expected_d;
    logic [31:0]  rx_count_q, rx_count_d;
    logic [15:0]  err_count_q, err_count_d;
    logic         err_sticky_q, err_sticky_d;
    logic [N-1:0] last_bad_q, last_bad_d;
    logic [N-1:0] last_exp_q, last_exp_d;
    logic         tready_q, tready_d;
    logic         halted_q, halted_d;

    logic              xfer_c;
    logic              mismatch_c;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] lfsr_next;
    logic              unused_lfsr;

    // Stall pattern source; only steps while the checker is running.
    axis_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_stall_lfsr (
        .clk          (clk),
        .resetn       (resetn),
        .en           (state_q == ST_RUN),
        .state        (lfsr_state),
        .state_next_c (lfsr_next)
    );

    assign unused_lfsr = ^{lfsr_state, lfsr_next[LFSR_W-1:1]};

    assign xfer_c     = (state_q == ST_RUN) && s_axis.tvalid && tready_q;
    assign mismatch_c = (s_axis.tdata != expected_q);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (xfer_c && mismatch_c && HALT_ON_ERROR) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
    end

    // Checker datapath and registered-output next values.
    always_comb begin
        expected_d   = expected_q;
        rx_count_d   = rx_count_q;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        last_bad_d   = last_bad_q;
        last_exp_d   = last_exp_q;

        if (xfer_c) begin
            rx_count_d = rx_count_q + 32'd1;
            if (mismatch_c) begin
                err_count_d  = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
                err_sticky_d = 1'b1;
                last_bad_d   = s_axis.tdata;
                last_exp_d   = expected_q;
                // Resync to the received value so a single skip costs one error.
                expected_d   = s_axis.tdata + N'(1);
            end else begin
                expected_d   = expected_q + N'(1);
            end
        end

        tready_d = (state_d == ST_RUN) && (STALL_MODE ? lfsr_next[0] : 1'b1);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            expected_q   <= '0;
            rx_count_q   <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
            last_bad_q   <= '0;
            last_exp_q   <= '0;
            tready_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            expected_q   <= expected_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
            last_bad_q   <= last_bad_d;
            last_exp_q   <= last_exp_d;
            tready_q     <= tready_d;
            halted_q     <= halted_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign rx_count      = rx_count_q;
    assign err_count     = err_count_q;
    assign err_sticky    = err_sticky_q;
    assign last_bad_data = last_bad_q;
    assign last_expected = last_exp_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_axis_ctr_rx.sv
// Bench for axis_ctr_rx. Four instances with different parameters share one
// stimulus stream; sel picks which instance the transmitter handshakes with
// and which one is checked.
//   0: byte_width 4, no stall, no halt
//   1: byte_width 1, no stall, no halt
//   2: byte_width 4, halt on error
//   3: byte_width 4, LFSR stall, seed 16'hACE1
module tb_axis_ctr_rx;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tvalid;
    logic [31:0] tdata;
    int          sel;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    axis_ctr_rx_if #(.DATA_W(32)) if0 ();
    axis_ctr_rx_if #(.DATA_W(8))  if1 ();
    axis_ctr_rx_if #(.DATA_W(32)) if2 ();
    axis_ctr_rx_if #(.DATA_W(32)) if3 ();

    assign if0.tvalid = tvalid;
    assign if1.tvalid = tvalid;
    assign if2.tvalid = tvalid;
    assign if3.tvalid = tvalid;
    assign if0.tdata  = tdata;
    assign if1.tdata  = tdata[7:0];
    assign if2.tdata  = tdata;
    assign if3.tdata  = tdata;

    logic        rdy [4];
    logic [31:0] rxc [4];
    logic [15:0] erc [4];
    logic        stk [4];
    logic        hlt [4];
    logic [31:0] lb  [4];
    logic [31:0] le  [4];
    logic [7:0]  lb1, le1;

    assign rdy[0] = if0.tready;
    assign rdy[1] = if1.tready;
    assign rdy[2] = if2.tready;
    assign rdy[3] = if3.tready;
    assign lb[1]  = {24'd0, lb1};
    assign le[1]  = {24'd0, le1};

    axis_ctr_rx #(.byte_width(4), .STALL_MODE(1'b0), .LFSR_SEED(16'hACE1), .HALT_ON_ERROR(1'b0)) u_dut0 (
        .clk(clk), .resetn(resetn), .s_axis(if0), .rx_count(rxc[0]), .err_count(erc[0]),
        .err_sticky(stk[0]), .last_bad_data(lb[0]), .last_expected(le[0]), .halted(hlt[0]));
    axis_ctr_rx #(.byte_width(1), .STALL_MODE(1'b0), .LFSR_SEED(16'hACE1), .HALT_ON_ERROR(1'b0)) u_dut1 (
        .clk(clk), .resetn(resetn), .s_axis(if1), .rx_count(rxc[1]), .err_count(erc[1]),
        .err_sticky(stk[1]), .last_bad_data(lb1), .last_expected(le1), .halted(hlt[1]));
    axis_ctr_rx #(.byte_width(4), .STALL_MODE(1'b0), .LFSR_SEED(16'hACE1), .HALT_ON_ERROR(1'b1)) u_dut2 (
        .clk(clk), .resetn(resetn), .s_axis(if2), .rx_count(rxc[2]), .err_count(erc[2]),
        .err_sticky(stk[2]), .last_bad_data(lb[2]), .last_expected(le[2]), .halted(hlt[2]));
    axis_ctr_rx #(.byte_width(4), .STALL_MODE(1'b1), .LFSR_SEED(16'hACE1), .HALT_ON_ERROR(1'b0)) u_dut3 (
        .clk(clk), .resetn(resetn), .s_axis(if3), .rx_count(rxc[3]), .err_count(erc[3]),
        .err_sticky(stk[3]), .last_bad_data(lb[3]), .last_expected(le[3]), .halted(hlt[3]));

    typedef struct {
        logic        vld;
        logic [31:0] d;
        logic [31:0] rx;
        logic [15:0] err;
        logic        stk;
        logic [31:0] bad;
        logic [31:0] lexp;
    } vec_t;

    vec_t vecs [12];

    // Reference Galois step, taps 16'hB400, right shift.
    function automatic logic [15:0] nx(input logic [15:0] s);
        nx = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Hold reset for two cycles, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Offer n counting beats starting at start; returns cycles spent.
    task automatic send(input int n, input logic [31:0] start, output int cycles);
        logic [31:0] d;
        int          left;
        d      = start;
        left   = n;
        cycles = 0;
        while (left > 0 && cycles < n + 1000) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = d;
            cycles++;
            if (rdy[sel]) begin
                d = d + 32'd1;
                left--;
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        check("send_timeout", 64'(left), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          hi_cnt;
        int          acc;
        logic [15:0] m;
        logic        exp_rdy;
        logic [31:0] d;

        vecs[0]  = '{1'b1, 32'd0,  32'd1,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[1]  = '{1'b1, 32'd1,  32'd2,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[2]  = '{1'b0, 32'd2,  32'd2,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[3]  = '{1'b1, 32'd2,  32'd3,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[4]  = '{1'b1, 32'd3,  32'd4,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[5]  = '{1'b1, 32'd4,  32'd5,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[6]  = '{1'b1, 32'd5,  32'd6,  16'd0, 1'b0, 32'd0,  32'd0};
        vecs[7]  = '{1'b1, 32'd9,  32'd7,  16'd1, 1'b1, 32'd9,  32'd6};
        vecs[8]  = '{1'b1, 32'd10, 32'd8,  16'd1, 1'b1, 32'd9,  32'd6};
        vecs[9]  = '{1'b1, 32'd11, 32'd9,  16'd1, 1'b1, 32'd9,  32'd6};
        vecs[10] = '{1'b1, 32'd13, 32'd10, 16'd2, 1'b1, 32'd13, 32'd12};
        vecs[11] = '{1'b1, 32'd14, 32'd11, 16'd2, 1'b1, 32'd13, 32'd12};

        // Reset values and first tready edge.
        sel    = 0;
        resetn = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_tready",  64'(rdy[0]), 64'd0);
        check("rst_rx",      64'(rxc[0]), 64'd0);
        check("rst_err",     64'(erc[0]), 64'd0);
        check("rst_sticky",  64'(stk[0]), 64'd0);
        check("rst_bad",     64'(lb[0]),  64'd0);
        check("rst_lexp",    64'(le[0]),  64'd0);
        check("rst_halted",  64'(hlt[0]), 64'd0);
        resetn = 1'b1;
        #1;
        check("tready_before_edge", 64'(rdy[0]), 64'd0);
        send(100, 32'd0, cyc);
        check("full_rate_cycles", 64'(cyc),    64'd100);
        check("run100_rx",        64'(rxc[0]), 64'd100);
        check("run100_err",       64'(erc[0]), 64'd0);
        check("run100_sticky",    64'(stk[0]), 64'd0);

        // Table: skip detection, resync, idle cycle.
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("vec_rx",     64'(rxc[0]), 64'(vecs[i-1].rx));
                check("vec_err",    64'(erc[0]), 64'(vecs[i-1].err));
                check("vec_sticky", 64'(stk[0]), 64'(vecs[i-1].stk));
                check("vec_bad",    64'(lb[0]),  64'(vecs[i-1].bad));
                check("vec_lexp",   64'(le[0]),  64'(vecs[i-1].lexp));
            end
            if (i < 12) begin
                check("vec_tready", 64'(rdy[0]), 64'd1);
                tvalid = vecs[i].vld;
                tdata  = vecs[i].d;
            end else begin
                tvalid = 1'b0;
            end
        end

        // 8-bit data wrap.
        sel = 1;
        do_reset();
        send(300, 32'd0, cyc);
        check("wrap_rx",     64'(rxc[1]), 64'd300);
        check("wrap_err",    64'(erc[1]), 64'd0);
        check("wrap_sticky", 64'(stk[1]), 64'd0);

        // Halt on first mismatch.
        sel = 2;
        do_reset();
        @(negedge clk);
        check("halt_pre_tready", 64'(rdy[2]), 64'd1);
        tvalid = 1'b1;
        tdata  = 32'd1;
        @(negedge clk);
        tdata = 32'd2;
        check("halt_halted", 64'(hlt[2]), 64'd1);
        check("halt_tready", 64'(rdy[2]), 64'd0);
        check("halt_rx",     64'(rxc[2]), 64'd1);
        check("halt_err",    64'(erc[2]), 64'd1);
        check("halt_bad",    64'(lb[2]),  64'd1);
        check("halt_lexp",   64'(le[2]),  64'd0);
        hi_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tdata = tdata + 32'd1;
            if (rdy[2] || !hlt[2]) hi_cnt++;
        end
        tvalid = 1'b0;
        check("halt_hold",   64'(hi_cnt), 64'd0);
        check("halt_rx_end", 64'(rxc[2]), 64'd1);

        // LFSR stall pattern and in-order delivery under backpressure.
        sel = 3;
        do_reset();
        m   = 16'hACE1;
        d   = 32'd0;
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            exp_rdy = nx(m)[0];
            if (c > 0) m = nx(m);
            check("stall_tready", 64'(rdy[3]), 64'(exp_rdy));
            tvalid = 1'b1;
            tdata  = d;
            if (rdy[3]) begin
                d = d + 32'd1;
                acc++;
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        check("stall_rx",  64'(rxc[3]), 64'(acc));
        check("stall_err", 64'(erc[3]), 64'd0);

        // Asynchronous reset mid-stream.
        sel = 0;
        do_reset();
        send(37, 32'd0, cyc);
        check("mid_rx_before", 64'(rxc[0]), 64'd37);
        tvalid = 1'b1;
        tdata  = 32'd37;
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rx",     64'(rxc[0]), 64'd0);
        check("mid_tready", 64'(rdy[0]), 64'd0);
        check("mid_err",    64'(erc[0]), 64'd0);
        check("mid_halted", 64'(hlt[0]), 64'd0);
        @(negedge clk);
        check("mid_held_beat", 64'(rxc[0]), 64'd0);
        resetn = 1'b1;
        send(20, 32'd0, cyc);
        check("mid_restart_rx",     64'(rxc[0]), 64'd20);
        check("mid_restart_err",    64'(erc[0]), 64'd0);
        check("mid_restart_sticky", 64'(stk[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_ctr_rx.md
# axis_ctr_rx

Receiving end of the AXI-Stream counter link: accepts beats from a counter transmitter, checks that data starts at 0 and increments by 1 per transfer (modulo 2^(8*byte_width)), and reports transfer and error statistics. It generates its own tready, either always-ready or with a pseudo-random stall pattern to exercise transmitter backpressure. It sits at the sink of loopback and bring-up test fabrics, paired with the counter transmitter.

## Interface
- byte_width, 4, tdata width in bytes; data width N = 8*byte_width
- STALL_MODE, 0, 0 = tready always high in RUN; 1 = tready follows LFSR stall pattern
- LFSR_SEED, 16'hACE1, nonzero reset value of the stall LFSR
- HALT_ON_ERROR, 0, 1 = first mismatch enters HALT; 0 = log and resync, keep running
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- tvalid  in  1  AXI-Stream valid from transmitter
- tready  out  1  AXI-Stream ready, registered
- tdata  in  N  AXI-Stream data
- rx_count  out  32  accepted transfers, wraps at 2^32
- err_count  out  16  mismatched transfers, saturates at 16'hFFFF
- err_sticky  out  1  set on first mismatch, cleared only by reset
- last_bad_data  out  N  tdata of most recent mismatched beat
- last_expected  out  N  expected value at most recent mismatch
- halted  out  1  high while in HALT

## Operation
- States: INIT, RUN, HALT. Reset -> INIT.
- INIT: tready=0; unconditionally -> RUN on first posedge after resetn release.
- RUN: transfer = tvalid && tready. On transfer compare tdata with expected (reset 0).
  - Match: expected <= expected+1 (mod 2^N); rx_count++.
  - Mismatch: rx_count++; err_count++ (saturating); err_sticky<=1; last_bad_data<=tdata; last_expected<=expected; expected <= tdata+1 (resync, mod 2^N); if HALT_ON_ERROR -> HALT.
- HALT: tready=0, no counters change; exits only via reset.
- tready (registered): next value = (next_state==RUN) && (STALL_MODE ? lfsr_next[0] : 1).
- LFSR: 16-bit Galois, taps mask 16'hB400, right-shift, advances every cycle while in RUN, holds otherwise; reset to LFSR_SEED.
- Receiver never waits on tvalid to raise tready; tready may drop without a transfer (permitted for receivers).
- Reset values: tready 0, rx_count 0, err_count 0, err_sticky 0, last_bad_data 0, last_expected 0, halted 0, expected 0.
- resetn assertion mid-stream: all state clears asynchronously; tready drops immediately; a beat held by transmitter across reset is not counted.

## Timing
- tready low during reset and until the first posedge after release; high (STALL_MODE=0) from that edge onward.
- Status outputs update on the same posedge that samples the transfer (1-cycle latency from transfer to visible count).
- Back-to-back transfers at full rate supported with STALL_MODE=0: one check per cycle, no bubbles.
- Expected wrap: after beat 2^N-1, next expected is 0 with no error.
- err_count at 16'hFFFF stays there; err_sticky and last_* still update.
- Mismatch in HALT_ON_ERROR=1: tready low from the edge after the bad beat; bad beat itself is counted.

## Structure
- Shared package axis_ctr_pkg: state encodings (INIT/RUN/HALT), LFSR width 16, tap mask 16'hB400, default seed; usable by the transmitter side for matching stall generators.
- Sub-module axis_lfsr16: enable, seed parameter, 16-bit state out, next-state out; instantiated once for the stall pattern.
- Checker FSM, compare, counters in top level.

## Test plan
- Reset release, tx counting from 0, STALL_MODE=0: tready high from first edge after release; after 100 beats rx_count=100, err_count=0, err_sticky=0.
- Inject tdata 5 when expecting 5 then 9 (skip): err_count=1, last_expected=6, last_bad_data=9, next beat 10 accepted without error.
- byte_width=1, run 300 beats from 0: wrap 255->0 clean; rx_count=300, err_count=0.
- HALT_ON_ERROR=1, first beat 1: halted=1, tready=0 next cycle and stays 0 for 50 cycles; rx_count=1.
- STALL_MODE=1, seed 16'hACE1: tready sequence matches reference LFSR model bit-for-bit; every beat the tx offers is eventually accepted in order, err_count=0.
- Assert resetn mid-stream after 37 beats: outputs return to reset values asynchronously; after release, stream restarting at 0 checks clean.
